// File: rtl/cdc_bit_receiver.sv
// cdc_bit_receiver
//   Receiving-domain stage for a single asynchronous CDC bit. The raw bit is
//   resynchronised through SYNC_STAGES flops. A level change is accepted only
//   after it has held for FILTER_LEN consecutive synchronised cycles, which
//   rejects short glitches. All outputs are registered.
//
//   Optional feature macro: CDC_RX_GLITCH_CNT_EN adds o_glitch_cnt, which
//   counts aborted qualifications.
//
// Ports
//   i_clk        receiving-domain clock
//   i_rst_n      synchronous active-low reset
//   i_data       asynchronous CDC bit from the transmitting domain
//   i_cnt_clr    one-cycle synchronous clear of the counter(s)
//   o_data       filtered, synchronised level
//   o_rise       one-cycle pulse on an accepted 0->1 transition
//   o_fall       one-cycle pulse on an accepted 1->0 transition
//   o_busy       high while a candidate transition is being qualified
//   o_edge_cnt   saturating count of accepted edges
//   o_glitch_cnt saturating count of aborted qualifications (macro only)
module cdc_bit_receiver #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_data,
   input  logic             i_cnt_clr,
   output logic             o_data,
   output logic             o_rise,
   output logic             o_fall,
   output logic             o_busy,
`ifdef CDC_RX_GLITCH_CNT_EN
   output logic [CNT_W-1:0] o_glitch_cnt,
`endif
   output logic [CNT_W-1:0] o_edge_cnt
);

   localparam int unsigned QW = $clog2(FILTER_LEN) + 1;
   localparam logic [QW-1:0] Q_LAST = QW'(FILTER_LEN - 1);

   typedef enum logic [1:0] {
      ST_LOW    = 2'd0,
      ST_QUAL_H = 2'd1,
      ST_HIGH   = 2'd2,
      ST_QUAL_L = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [QW-1:0]          q_q, q_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   data_q, data_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   busy_q, busy_d;
   logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0]       glitch_cnt_q, glitch_cnt_d;
   logic                   s;
   logic                   edge_ev;
   logic                   glitch_ev;

   // Synchroniser shift chain; i_data feeds the first flop directly.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_data};
      s      = sync_q[SYNC_STAGES-1];
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_LOW;
         q_q     <= '0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         sync_q  <= sync_d;
      end
   end

   // Next-state logic: a new level must hold FILTER_LEN synchronised cycles.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      case (state_q)
         ST_LOW: begin
            if (s) begin
               if (FILTER_LEN == 1) begin
                  state_d = ST_HIGH;
               end else begin
                  state_d = ST_QUAL_H;
                  q_d     = QW'(1);
               end
            end
         end
         ST_QUAL_H: begin
            if (!s)                 state_d = ST_LOW;
            else if (q_q == Q_LAST) state_d = ST_HIGH;
            else                    q_d     = q_q + QW'(1);
         end
         ST_HIGH: begin
            if (!s) begin
               if (FILTER_LEN == 1) begin
                  state_d = ST_LOW;
               end else begin
                  state_d = ST_QUAL_L;
                  q_d     = QW'(1);
               end
            end
         end
         ST_QUAL_L: begin
            if (s)                  state_d = ST_HIGH;
            else if (q_q == Q_LAST) state_d = ST_LOW;
            else                    q_d     = q_q + QW'(1);
         end
         default: state_d = ST_LOW;
      endcase
   end

   // Output logic: registered outputs are computed from the upcoming state.
   always_comb begin
      data_d    = (state_d == ST_HIGH) || (state_d == ST_QUAL_L);
      busy_d    = (state_d == ST_QUAL_H) || (state_d == ST_QUAL_L);
      // Returning to HIGH from QUAL_L (or LOW from QUAL_H) is an abort, not an edge.
      rise_d    = (state_d == ST_HIGH) &&
                  ((state_q == ST_LOW) || (state_q == ST_QUAL_H));
      fall_d    = (state_d == ST_LOW) &&
                  ((state_q == ST_HIGH) || (state_q == ST_QUAL_L));
      glitch_ev = ((state_q == ST_QUAL_H) && (state_d == ST_LOW)) ||
                  ((state_q == ST_QUAL_L) && (state_d == ST_HIGH));
      edge_ev   = rise_d || fall_d;

      // A clear coinciding with an event leaves the count at 1.
      edge_cnt_d = edge_cnt_q;
      if (i_cnt_clr)                         edge_cnt_d = CNT_W'(edge_ev);
      else if (edge_ev && (edge_cnt_q != '1)) edge_cnt_d = edge_cnt_q + CNT_W'(1);

      glitch_cnt_d = glitch_cnt_q;
      if (i_cnt_clr)                             glitch_cnt_d = CNT_W'(glitch_ev);
      else if (glitch_ev && (glitch_cnt_q != '1)) glitch_cnt_d = glitch_cnt_q + CNT_W'(1);
   end

   // Output registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         data_q       <= 1'b0;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         busy_q       <= 1'b0;
         edge_cnt_q   <= '0;
         glitch_cnt_q <= '0;
      end else begin
         data_q       <= data_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         busy_q       <= busy_d;
         edge_cnt_q   <= edge_cnt_d;
         glitch_cnt_q <= glitch_cnt_d;
      end
   end

   assign o_data     = data_q;
   assign o_rise     = rise_q;
   assign o_fall     = fall_q;
   assign o_busy     = busy_q;
   assign o_edge_cnt = edge_cnt_q;

`ifdef CDC_RX_GLITCH_CNT_EN
   assign o_glitch_cnt = glitch_cnt_q;
`else
   // Glitch counter is unobservable without the port; keep it referenced.
   logic glitch_unused;
   assign glitch_unused = ^glitch_cnt_q;
`endif

endmodule

// File: tb/tb_cdc_bit_receiver.sv
// Testbench for cdc_bit_receiver: a default instance and a CNT_W=4 instance
// share stimulus; a table, hand sequences and a run-length reference model
// check both.
module tb_cdc_bit_receiver;

   localparam int SYNC = 2;
   localparam int FLEN = 4;

   logic clk = 1'b0;
   logic rst_n, d, clr;

   logic        o_data, o_rise, o_fall, o_busy;
   logic [15:0] o_cnt;
   logic        o4_data, o4_rise, o4_fall, o4_busy;
   logic [3:0]  o4_cnt;
`ifdef CDC_RX_GLITCH_CNT_EN
   logic [15:0] o_gcnt;
   logic [3:0]  o4_gcnt;
`endif

   always #5 clk = ~clk;

   cdc_bit_receiver dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(d), .i_cnt_clr(clr),
      .o_data(o_data), .o_rise(o_rise), .o_fall(o_fall), .o_busy(o_busy),
`ifdef CDC_RX_GLITCH_CNT_EN
      .o_glitch_cnt(o_gcnt),
`endif
      .o_edge_cnt(o_cnt)
   );

   cdc_bit_receiver #(.SYNC_STAGES(2), .FILTER_LEN(4), .CNT_W(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(d), .i_cnt_clr(clr),
      .o_data(o4_data), .o_rise(o4_rise), .o_fall(o4_fall), .o_busy(o4_busy),
`ifdef CDC_RX_GLITCH_CNT_EN
      .o_glitch_cnt(o4_gcnt),
`endif
      .o_edge_cnt(o4_cnt)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: accepted level plus length of the current run of
   // synchronised samples that disagree with it.
   logic m_sync [SYNC];
   logic m_lvl, m_rise, m_fall, m_busy;
   int   m_run, m_cnt16, m_cnt4, m_g16, m_g4;

   function automatic int upd(input int c, input bit ev, input bit cl, input int mx);
      if (cl) return ev ? 1 : 0;
      if (ev && c < mx) return c + 1;
      return c;
   endfunction

   always @(posedge clk) begin
      logic s;
      bit   acc, gl;
      if (!rst_n) begin
         for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
         m_lvl = 0; m_run = 0; m_rise = 0; m_fall = 0; m_busy = 0;
         m_cnt16 = 0; m_cnt4 = 0; m_g16 = 0; m_g4 = 0;
      end else begin
         s = m_sync[SYNC-1];
         for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
         m_sync[0] = d;
         acc = 0; gl = 0;
         if (s != m_lvl) begin
            m_run++;
            if (m_run == FLEN) begin
               acc = 1; m_lvl = s; m_run = 0;
            end
         end else begin
            gl = (m_run > 0);
            m_run = 0;
         end
         m_rise  = acc && m_lvl;
         m_fall  = acc && !m_lvl;
         m_busy  = (m_run > 0);
         m_cnt16 = upd(m_cnt16, acc, clr, 65535);
         m_cnt4  = upd(m_cnt4, acc, clr, 15);
         m_g16   = upd(m_g16, gl, clr, 65535);
         m_g4    = upd(m_g4, gl, clr, 15);
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("model_data", o_data, m_lvl);
      chk("model_rise", o_rise, m_rise);
      chk("model_fall", o_fall, m_fall);
      chk("model_busy", o_busy, m_busy);
      chk("model_cnt16", o_cnt, m_cnt16);
      chk("model_data4", o4_data, m_lvl);
      chk("model_cnt4", o4_cnt, m_cnt4);
      chk("rise_fall_excl", o_rise & o_fall, 0);
`ifdef CDC_RX_GLITCH_CNT_EN
      chk("model_gcnt16", o_gcnt, m_g16);
      chk("model_gcnt4", o4_gcnt, m_g4);
`endif
   endtask

   // Advance one clock; inputs are set before the call, outputs sampled on negedge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic rst_n, d, clr;
      logic e_data, e_rise, e_fall, e_busy;
      int   e_cnt;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int hold;
      // Reset with i_data high, then release: edges 1..9 after release.
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};

      rst_n = 1'b0; d = 1'b1; clr = 1'b0;
      for (int i = 0; i < 11; i++) begin
         rst_n = tbl[i].rst_n; d = tbl[i].d; clr = tbl[i].clr;
         step();
         chk($sformatf("tbl%0d_data", i), o_data, tbl[i].e_data);
         chk($sformatf("tbl%0d_rise", i), o_rise, tbl[i].e_rise);
         chk($sformatf("tbl%0d_fall", i), o_fall, tbl[i].e_fall);
         chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].e_busy);
         chk($sformatf("tbl%0d_cnt", i), o_cnt, tbl[i].e_cnt);
         if (tbl[i].rst_n) check_model();
      end

      // Accepted fall: single pulse after edge 6 of the low level.
      d = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         step();
         chk($sformatf("fall_e%0d_pulse", e), o_fall, (e == 6) ? 1 : 0);
         chk($sformatf("fall_e%0d_data", e), o_data, (e < 6) ? 1 : 0);
      end
      chk("fall_cnt", o_cnt, 2);

      // Three-cycle high glitch from stable low is rejected.
      d = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         if (e == 4) d = 1'b0;
         step();
         chk($sformatf("glitch_e%0d_rise", e), o_rise, 0);
         chk($sformatf("glitch_e%0d_data", e), o_data, 0);
      end
      chk("glitch_cnt_edges", o_cnt, 2);
`ifdef CDC_RX_GLITCH_CNT_EN
      chk("glitch_cnt", o_gcnt, 1);
`endif

      // Clear coinciding with an accepted rise leaves the count at 1.
      d = 1'b1;
      for (int e = 1; e <= 5; e++) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_coinc_rise", o_rise, 1);
      chk("clr_coinc_cnt", o_cnt, 1);
      chk("clr_coinc_cnt4", o4_cnt, 1);
      for (int e = 0; e < 3; e++) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_alone_cnt", o_cnt, 0);
      chk("clr_alone_data", o_data, 1);

      // Reset pulse during QUAL_H, then re-qualification from scratch.
      d = 1'b0;
      for (int e = 0; e < 8; e++) step();
      chk("pre_rst_data", o_data, 0);
      d = 1'b1;
      for (int e = 0; e < 3; e++) step();
      chk("qualh_busy", o_busy, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rst_data", o_data, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_rise", o_rise, 0);
      chk("rst_fall", o_fall, 0);
      chk("rst_cnt", o_cnt, 0);
      for (int e = 1; e <= 7; e++) begin
         step();
         chk($sformatf("rerise_e%0d", e), o_rise, (e == 6) ? 1 : 0);
      end
      chk("rerise_cnt", o_cnt, 1);

      // Saturation: 20 clean toggles spaced 10 cycles apart.
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("sat_pre_cnt4", o4_cnt, 0);
      for (int t = 0; t < 20; t++) begin
         d = ~d;
         for (int e = 0; e < 10; e++) step();
      end
      chk("sat_cnt4", o4_cnt, 15);
      chk("sat_cnt16", o_cnt, 20);
      check_model();

      // Randomised bursts checked against the reference model every cycle.
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         if (hold == 0) begin
            d = ~d;
            hold = $urandom_range(1, 7);
         end
         hold--;
         clr   = ($urandom_range(0, 15) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
         step();
         check_model();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
